program_loader: RTL and testbench

Boot-time loader upstream of the processor's instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive instruction-memory word addresses starting at 0. It verifies a trailing XOR checksum and holds the core in reset until a load session completes cleanly.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_byte_packer.sv | 39 +++
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encodings,
// stream framing constants and the checksum step helper.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Big-endian byte-to-word packer. Holds the three earlier bytes of the
// current word; the incoming byte completes it combinationally so the
// loader can register the full word on the 4th byte's edge.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  assign word      = {r_shift, byte_in};
  assign word_full = push && (r_idx == 2'(WORD_BYTES - 1));

  // Shift accepted bytes in MSB first; a new session discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= 24'h000000;
      r_idx   <= 2'd0;
    end else if (clear) begin
      r_shift <= 24'h000000;
      r_idx   <= 2'd0;
    end else if (push) begin
      r_shift <= {r_shift[15:0], byte_in};
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_shift <= r_shift;
      r_idx   <= r_idx;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: receives a counted, checksummed byte stream, writes
// big-endian words to instruction memory from address 0 and releases the
// core from reset only after a session completes with a matching checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t              r_state;
  logic [15:0]         r_count;
  logic                r_hdr_idx;
  logic [ADDR_WIDTH:0] r_k;
  logic [7:0]          r_csum;
  logic                r_rx_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_core_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_accept;
  logic                w_push;
  logic                w_clear;
  logic [31:0]         w_word;
  logic                w_word_full;
  logic [15:0]         w_count;
  logic [ADDR_WIDTH:0] w_k_next;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_push   = w_accept && (r_state == ST_DATA);
  assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_count  = {r_count[15:8], rx_data};
  assign w_k_next = r_k + {{ADDR_WIDTH{1'b0}}, 1'b1};

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .push      (w_push),
    .byte_in   (rx_data),
    .word      (w_word),
    .word_full (w_word_full)
  );

  // Loader FSM with counters, checksum and registered memory/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= 16'h0000;
      r_hdr_idx   <= 1'b0;
      r_k         <= '0;
      r_csum      <= 8'h00;
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h00000000;
      r_mem_wdata <= 32'h00000000;
      r_core_hold <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state     <= ST_HDR;
            r_count     <= 16'h0000;
            r_hdr_idx   <= 1'b0;
            r_k         <= '0;
            r_csum      <= 8'h00;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_core_hold <= 1'b1;
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            if (!r_hdr_idx) begin
              r_count[15:8] <= rx_data;
              r_hdr_idx     <= 1'b1;
            end else begin
              r_count <= w_count;
              if ({1'b0, w_count} > MAX_WORDS) begin
                r_state    <= ST_ERR;
                r_rx_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_error    <= 1'b1;
              end else if (w_count == 16'h0000) begin
                r_state <= ST_CSUM;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_csum <= csum_step(r_csum, rx_data);
            if (w_word_full) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= 32'(r_k);
              r_mem_wdata <= w_word;
              r_k         <= w_k_next;
              if (17'(w_k_next) == {1'b0, r_count}) begin
                r_state <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (rx_data == r_csum) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_core_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready  = r_rx_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_hold = r_core_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (ADDR_WIDTH = 2, so the
// maximum image is 4 words and the oversize header is 5).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(.ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: record every strobe and require each to last one cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      check("mem_we_one_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_we;
  end

  typedef struct packed {
    logic [15:0]       n;
    logic [3:0][31:0]  w;
    logic [7:0]        csum;
    logic [1:0]        gap;
    logic [2:0]        exp_writes;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic [7:0] cs,
                              input logic [1:0] gap, input logic [2:0] nwr, input logic d,
                              input logic e);
    vec_t v;
    v.n = n;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    v.csum = cs;
    v.gap = gap;
    v.exp_writes = nwr;
    v.exp_done = d;
    v.exp_err = e;
    return v;
  endfunction

  // Entered at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic accepted;
    accepted = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_ready) begin
        accepted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic check_writes(input int nwr, input vec_t v);
    check("write_count", 32'(q_addr.size()), 32'(nwr));
    for (int i = 0; i < nwr && i < q_addr.size(); i++) begin
      check("write_addr", q_addr[i], 32'(i));
      check("write_data", q_data[i], v.w[i]);
    end
  endtask

  vec_t vecs[6];
  vec_t v1;

  initial begin
    vecs[0] = mk(16'd3, 32'h20080005, 32'h20090007, 32'h01095020, 32'h0, 8'h7B, 2'd0, 3'd3, 1'b1, 1'b0);
    vecs[1] = mk(16'd3, 32'h20080005, 32'h20090007, 32'h01095020, 32'h0, 8'h7A, 2'd0, 3'd3, 1'b0, 1'b1);
    vecs[2] = mk(16'd5, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b1);
    vecs[3] = mk(16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 2'd0, 3'd0, 1'b1, 1'b0);
    vecs[4] = mk(16'd3, 32'h20080005, 32'h20090007, 32'h01095020, 32'h0, 8'h7B, 2'd3, 3'd3, 1'b1, 1'b0);
    vecs[5] = mk(16'd4, 32'h20080005, 32'h20090007, 32'h01095020, 32'hDEADBEEF, 8'h59, 2'd0, 3'd4, 1'b1, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven sessions.
    for (int t = 0; t < 6; t++) begin
      q_addr.delete();
      q_data.delete();
      pulse_start();
      check("busy_in_session", {31'd0, busy}, 32'd1);
      check("hold_in_session", {31'd0, core_hold}, 32'd1);
      send_byte(vecs[t].n[15:8], int'(vecs[t].gap));
      send_byte(vecs[t].n[7:0], int'(vecs[t].gap));
      if (vecs[t].n <= 16'd4) begin
        for (int k = 0; k < int'(vecs[t].n); k++) begin
          send_word(vecs[t].w[k], int'(vecs[t].gap));
        end
        send_byte(vecs[t].csum, int'(vecs[t].gap));
      end
      rx_valid = 1'b0;
      check("done", {31'd0, done}, {31'd0, vecs[t].exp_done});
      check("error", {31'd0, error}, {31'd0, vecs[t].exp_err});
      check("core_hold", {31'd0, core_hold}, {31'd0, ~vecs[t].exp_done});
      check("rx_ready_after", {31'd0, rx_ready}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check_writes(int'(vecs[t].exp_writes), vecs[t]);
    end

    // Start pulse during DATA is ignored.
    q_addr.delete();
    q_data.delete();
    v1 = mk(16'd2, 32'h20080005, 32'h20090007, 32'h0, 32'h0, 8'h03, 2'd0, 3'd2, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    pulse_start();
    check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_word(32'h20090007, 0);
    send_byte(8'h03, 0);
    rx_valid = 1'b0;
    check("ign_start_done", {31'd0, done}, 32'd1);
    check("ign_start_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_writes(2, v1);

    // Abort by reset after 6 payload bytes, then a fresh 1-word session.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(32'h20080005, 0);
    send_byte(8'h20, 0);
    send_byte(8'h09, 0);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_core_hold", {31'd0, core_hold}, 32'd1);
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q_addr.delete();
    q_data.delete();
    v1 = mk(16'd1, 32'h12345678, 32'h0, 32'h0, 32'h0, 8'h08, 2'd0, 3'd1, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h12345678, 0);
    send_byte(8'h08, 0);
    rx_valid = 1'b0;
    check("restart_done", {31'd0, done}, 32'd1);
    check("restart_core_hold", {31'd0, core_hold}, 32'd0);
    @(negedge clk);
    check_writes(1, v1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
